// File: rtl/etapa_mem_acceso_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface etapa_mem_acceso_if #(
    parameter int unsigned NBITS = 32
);
    logic             o_mem_req;
    logic             o_mem_we;
    logic [NBITS-1:0] o_mem_addr;
    logic [NBITS-1:0] o_mem_wdata;
    logic [3:0]       o_mem_be;
    logic             i_mem_ack;
    logic [NBITS-1:0] i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/etapa_mem_acceso.sv
// MEM pipeline stage: drives loads/stores over a req/ack memory bus, stalls until completion,
// steers store lanes, filters/extends load data and registers the MEM/WB outputs.
module etapa_mem_acceso #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned REGS    = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NBITS-1:0]   i_ALU,
    input  logic [NBITS-1:0]   i_Registro2,
    input  logic [REGS-1:0]    i_RegistroDestino,
    input  logic               i_MemRead,
    input  logic               i_MemWrite,
    input  logic [1:0]         i_TamanoFiltro,
    input  logic [1:0]         i_TamanoFiltroL,
    input  logic               i_ZeroExtend,
    input  logic               i_MemToReg,
    input  logic               i_RegWrite,
    etapa_mem_acceso_if.master mem,
    output logic               o_stall,
    output logic               o_misaligned,
    output logic               o_bus_error,
    output logic [NBITS-1:0]   o_ReadData,
    output logic [NBITS-1:0]   o_ALU,
    output logic [REGS-1:0]    o_RegistroDestino,
    output logic               o_MemToReg,
    output logic               o_RegWrite
);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT);
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [NBITS-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [1:0]       lsize_q, lsize_d;
    logic             zext_q, zext_d;
    logic [REGS-1:0]  hold_rd_q, hold_rd_d;
    logic             hold_m2r_q, hold_m2r_d;
    logic             hold_rw_q, hold_rw_d;

    logic [NBITS-1:0] wb_data_q, wb_data_d;
    logic [NBITS-1:0] wb_alu_q, wb_alu_d;
    logic [REGS-1:0]  wb_rd_q, wb_rd_d;
    logic             wb_m2r_q, wb_m2r_d;
    logic             wb_rw_q, wb_rw_d;
    logic             misal_q, misal_d;
    logic             berr_q, berr_d;

    logic             stall_c;
    logic             access_c, store_c, misaligned_c;
    logic [1:0]       size_c;
    logic [3:0]       be_new_c;
    logic [NBITS-1:0] wdata_new_c;

    // Select the addressed byte/half of a read word and extend it to the datapath width.
    function automatic logic [NBITS-1:0] filtrar_carga(input logic [NBITS-1:0] word,
                                                       input logic [1:0]       lane,
                                                       input logic [1:0]       size,
                                                       input logic             zext);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [NBITS-1:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{(NBITS-8){~zext & b[7]}}, b};
            SZ_HALF: res = {{(NBITS-16){~zext & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode of the incoming access; a simultaneous read and write is handled as a store.
    always_comb begin
        access_c = i_MemRead | i_MemWrite;
        store_c  = i_MemWrite;
        size_c   = store_c ? i_TamanoFiltro : i_TamanoFiltroL;
        misaligned_c = ((size_c == SZ_HALF) && i_ALU[0]) ||
                       (size_c[1] && (i_ALU[1:0] != 2'b00));
        case (size_c)
            SZ_BYTE: begin
                be_new_c    = 4'b0001 << i_ALU[1:0];
                wdata_new_c = {4{i_Registro2[7:0]}};
            end
            SZ_HALF: begin
                be_new_c    = i_ALU[1] ? 4'b1100 : 4'b0011;
                wdata_new_c = {2{i_Registro2[15:0]}};
            end
            default: begin
                be_new_c    = 4'b1111;
                wdata_new_c = i_Registro2;
            end
        endcase
    end

    // Next-state, latch and MEM/WB logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        lsize_d    = lsize_q;
        zext_d     = zext_q;
        hold_rd_d  = hold_rd_q;
        hold_m2r_d = hold_m2r_q;
        hold_rw_d  = hold_rw_q;
        wb_data_d  = '0;
        wb_alu_d   = i_ALU;
        wb_rd_d    = i_RegistroDestino;
        wb_m2r_d   = i_MemToReg;
        wb_rw_d    = i_RegWrite;
        misal_d    = 1'b0;
        berr_d     = 1'b0;
        stall_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_c && misaligned_c) begin
                    wb_rw_d  = 1'b0;
                    wb_m2r_d = 1'b0;
                    misal_d  = 1'b1;
                end else if (access_c) begin
                    stall_c    = 1'b1;
                    wb_rw_d    = 1'b0;
                    wb_m2r_d   = 1'b0;
                    state_d    = BUSY;
                    cnt_d      = '0;
                    req_d      = 1'b1;
                    we_d       = store_c;
                    addr_d     = i_ALU;
                    wdata_d    = wdata_new_c;
                    be_d       = be_new_c;
                    lsize_d    = i_TamanoFiltroL;
                    zext_d     = i_ZeroExtend;
                    hold_rd_d  = i_RegistroDestino;
                    hold_m2r_d = i_MemToReg;
                    hold_rw_d  = i_RegWrite;
                end
            end
            BUSY: begin
                cnt_d    = cnt_q + CNT_W'(1);
                wb_alu_d = addr_q;
                wb_rd_d  = hold_rd_q;
                if (mem.i_mem_ack) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    wb_m2r_d  = hold_m2r_q;
                    wb_rw_d   = hold_rw_q;
                    wb_data_d = we_q ? '0 : filtrar_carga(mem.i_mem_rdata, addr_q[1:0], lsize_q, zext_q);
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    cnt_d    = '0;
                    wb_m2r_d = 1'b0;
                    wb_rw_d  = 1'b0;
                    berr_d   = 1'b1;
                end else begin
                    stall_c  = 1'b1;
                    wb_m2r_d = 1'b0;
                    wb_rw_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            lsize_q    <= '0;
            zext_q     <= 1'b0;
            hold_rd_q  <= '0;
            hold_m2r_q <= 1'b0;
            hold_rw_q  <= 1'b0;
            wb_data_q  <= '0;
            wb_alu_q   <= '0;
            wb_rd_q    <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            misal_q    <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            lsize_q    <= lsize_d;
            zext_q     <= zext_d;
            hold_rd_q  <= hold_rd_d;
            hold_m2r_q <= hold_m2r_d;
            hold_rw_q  <= hold_rw_d;
            wb_data_q  <= wb_data_d;
            wb_alu_q   <= wb_alu_d;
            wb_rd_q    <= wb_rd_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            misal_q    <= misal_d;
            berr_q     <= berr_d;
        end
    end

    assign mem.o_mem_req   = req_q;
    assign mem.o_mem_we    = we_q;
    assign mem.o_mem_addr  = {addr_q[NBITS-1:2], 2'b00};
    assign mem.o_mem_wdata = wdata_q;
    assign mem.o_mem_be    = be_q;

    assign o_stall           = stall_c;
    assign o_misaligned      = misal_q;
    assign o_bus_error       = berr_q;
    assign o_ReadData        = wb_data_q;
    assign o_ALU             = wb_alu_q;
    assign o_RegistroDestino = wb_rd_q;
    assign o_MemToReg        = wb_m2r_q;
    assign o_RegWrite        = wb_rw_q;
endmodule

// File: tb/tb_etapa_mem_acceso.sv
// Bench for etapa_mem_acceso: vector table with a scoreboard of expected MEM/WB results,
// plus hand sequences for reset, stray ack after timeout and reset during a pending access.
module tb_etapa_mem_acceso;
    localparam int unsigned NBITS   = 32;
    localparam int unsigned REGS    = 5;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic        misal;
        logic        berr;
    } wb_t;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [1:0]  ssz;
        logic [1:0]  lsz;
        logic        zx;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        int          ack_at;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        wb_t         exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NBITS-1:0]  alu, reg2;
    logic [REGS-1:0]   rdest;
    logic              mem_read, mem_write, zext, m2r, rw;
    logic [1:0]        tam, taml;
    logic              stall, misal, berr, o_m2r, o_rw;
    logic [NBITS-1:0]  rdata_o, alu_o;
    logic [REGS-1:0]   rd_o;

    int checks   = 0;
    int failures = 0;
    wb_t  sb[$];
    vec_t vecs[14];

    always #5 clk = ~clk;

    etapa_mem_acceso_if #(.NBITS(NBITS)) mem_if ();

    etapa_mem_acceso #(.NBITS(NBITS), .REGS(REGS), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_ALU(alu), .i_Registro2(reg2),
        .i_RegistroDestino(rdest), .i_MemRead(mem_read), .i_MemWrite(mem_write),
        .i_TamanoFiltro(tam), .i_TamanoFiltroL(taml), .i_ZeroExtend(zext),
        .i_MemToReg(m2r), .i_RegWrite(rw), .mem(mem_if),
        .o_stall(stall), .o_misaligned(misal), .o_bus_error(berr),
        .o_ReadData(rdata_o), .o_ALU(alu_o), .o_RegistroDestino(rd_o),
        .o_MemToReg(o_m2r), .o_RegWrite(o_rw)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd_en, input logic wr_en, input logic [1:0] ssz,
                                input logic [1:0] lsz, input logic zx, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                input logic [4:0] rd, input logic m2r_i, input logic rw_i,
                                input int ack_at, input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input logic exp_rw,
                                input logic exp_m2r, input logic exp_misal, input logic exp_berr);
        vec_t v;
        v.rd_en = rd_en; v.wr_en = wr_en; v.ssz = ssz; v.lsz = lsz; v.zx = zx;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rd = rd; v.m2r = m2r_i; v.rw = rw_i;
        v.ack_at = ack_at; v.exp_be = be; v.exp_wdata = wdata;
        v.exp = '{data: exp_data, alu: addr, rd: rd, m2r: exp_m2r, rw: exp_rw,
                  misal: exp_misal, berr: exp_berr};
        return v;
    endfunction

    task automatic drive_nop();
        alu = '0; reg2 = '0; rdest = '0; mem_read = 1'b0; mem_write = 1'b0;
        tam = 2'b00; taml = 2'b00; zext = 1'b0; m2r = 1'b0; rw = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        wb_t e;
        int  k, stall_cnt, exp_stall;
        bit  acc, done;
        @(posedge clk); #1;
        alu = v.addr; reg2 = v.sdata; rdest = v.rd; mem_read = v.rd_en; mem_write = v.wr_en;
        tam = v.ssz; taml = v.lsz; zext = v.zx; m2r = v.m2r; rw = v.rw;
        mem_if.i_mem_ack = 1'b0;
        sb.push_back(v.exp);
        acc = (v.rd_en || v.wr_en) && !v.exp.misal;
        @(negedge clk);
        check($sformatf("v%0d stall_first", idx), 32'(stall), 32'(acc));
        check($sformatf("v%0d req_first", idx), 32'(mem_if.o_mem_req), 32'd0);
        if (acc) begin
            k = 0; done = 1'b0; stall_cnt = 1;
            while (!done) begin
                @(posedge clk); #1;
                k++;
                mem_if.i_mem_ack   = (k == v.ack_at);
                mem_if.i_mem_rdata = (k == v.ack_at) ? v.rdata : $urandom;
                @(negedge clk);
                check($sformatf("v%0d req_busy%0d", idx, k), 32'(mem_if.o_mem_req), 32'd1);
                if (k == 1) begin
                    check($sformatf("v%0d we", idx), 32'(mem_if.o_mem_we), 32'(v.wr_en));
                    check($sformatf("v%0d addr", idx), mem_if.o_mem_addr, {v.addr[31:2], 2'b00});
                    if (v.wr_en) begin
                        check($sformatf("v%0d be", idx), 32'(mem_if.o_mem_be), 32'(v.exp_be));
                        check($sformatf("v%0d wdata", idx), mem_if.o_mem_wdata, v.exp_wdata);
                    end
                end
                if (k == v.ack_at || k == int'(TIMEOUT)) done = 1'b1;
                else stall_cnt++;
                if (stall === 1'b1) begin end
                check($sformatf("v%0d stall_busy%0d", idx, k), 32'(stall), 32'(!done));
            end
            exp_stall = (v.ack_at == 0) ? int'(TIMEOUT) : v.ack_at;
            check($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(exp_stall));
        end
        @(posedge clk); #1;
        mem_if.i_mem_ack = 1'b0;
        drive_nop();
        @(negedge clk);
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL v%0d scoreboard_empty actual=0 required=1", idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d ReadData", idx), rdata_o, e.data);
            check($sformatf("v%0d ALU", idx), alu_o, e.alu);
            check($sformatf("v%0d RegDest", idx), 32'(rd_o), 32'(e.rd));
            check($sformatf("v%0d MemToReg", idx), 32'(o_m2r), 32'(e.m2r));
            check($sformatf("v%0d RegWrite", idx), 32'(o_rw), 32'(e.rw));
            check($sformatf("v%0d misaligned", idx), 32'(misal), 32'(e.misal));
            check($sformatf("v%0d bus_error", idx), 32'(berr), 32'(e.berr));
            check($sformatf("v%0d req_after", idx), 32'(mem_if.o_mem_req), 32'd0);
        end
    endtask

    // Stray ack arriving after a timeout must be ignored; error pulse lasts one cycle.
    task automatic stray_ack();
        @(posedge clk); #1;
        mem_if.i_mem_ack   = 1'b1;
        mem_if.i_mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        check("stray req", 32'(mem_if.o_mem_req), 32'd0);
        check("stray stall", 32'(stall), 32'd0);
        check("stray berr_pulse_end", 32'(berr), 32'd0);
        @(posedge clk); #1;
        mem_if.i_mem_ack = 1'b0;
        @(negedge clk);
        check("stray ReadData", rdata_o, 32'd0);
        check("stray RegWrite", 32'(o_rw), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(0,0,2'b00,2'b00,0,32'h1234_5678,32'h0,32'h0,5'd7,0,1, 0,4'h0,32'h0,
                      32'h0,1,0,0,0);
        vecs[1]  = mk(0,1,2'b10,2'b00,0,32'h10,32'hDEAD_BEEF,32'h0,5'd0,0,0, 3,4'hF,32'hDEAD_BEEF,
                      32'h0,0,0,0,0);
        vecs[2]  = mk(1,0,2'b00,2'b00,0,32'h23,32'h0,32'h80FF_FF12,5'd5,1,1, 1,4'h0,32'h0,
                      32'hFFFF_FF80,1,1,0,0);
        vecs[3]  = mk(1,0,2'b00,2'b00,1,32'h23,32'h0,32'h80FF_FF12,5'd5,1,1, 2,4'h0,32'h0,
                      32'h0000_0080,1,1,0,0);
        vecs[4]  = mk(0,1,2'b01,2'b00,0,32'h06,32'h0000_ABCD,32'h0,5'd0,0,0, 1,4'hC,32'hABCD_ABCD,
                      32'h0,0,0,0,0);
        vecs[5]  = mk(1,0,2'b00,2'b10,0,32'h02,32'h0,32'h0,5'd9,0,1, 0,4'h0,32'h0,
                      32'h0,0,0,1,0);
        vecs[6]  = mk(1,0,2'b00,2'b01,0,32'h06,32'h0,32'h8001_7FFF,5'd10,1,1, 4,4'h0,32'h0,
                      32'hFFFF_8001,1,1,0,0);
        vecs[7]  = mk(1,0,2'b00,2'b01,1,32'h04,32'h0,32'h8001_7FFF,5'd11,1,1, 2,4'h0,32'h0,
                      32'h0000_7FFF,1,1,0,0);
        vecs[8]  = mk(0,1,2'b00,2'b00,0,32'h11,32'h0000_00A5,32'h0,5'd0,0,0, 1,4'h2,32'hA5A5_A5A5,
                      32'h0,0,0,0,0);
        vecs[9]  = mk(1,0,2'b00,2'b10,0,32'h40,32'h0,32'hCAFE_F00D,5'd12,1,1, 16,4'h0,32'h0,
                      32'hCAFE_F00D,1,1,0,0);
        vecs[10] = mk(0,1,2'b01,2'b00,0,32'h05,32'h0000_1234,32'h0,5'd0,0,1, 0,4'h0,32'h0,
                      32'h0,0,0,1,0);
        vecs[11] = mk(1,0,2'b00,2'b10,0,32'h08,32'h0,32'h0,5'd13,0,1, 0,4'h0,32'h0,
                      32'h0,0,0,0,1);
        vecs[12] = mk(1,1,2'b00,2'b10,0,32'h03,32'h0000_0077,32'h0,5'd0,0,0, 1,4'h8,32'h7777_7777,
                      32'h0,0,0,0,0);
        vecs[13] = mk(1,0,2'b00,2'b10,0,32'h0C,32'h0,32'h1234_5678,5'd14,1,1, 1,4'h0,32'h0,
                      32'h1234_5678,1,1,0,0);

        // Reset held two cycles with non-zero inputs that must not reach the outputs.
        rst_n = 1'b0;
        drive_nop();
        alu = 32'hFFFF_FFFF; rdest = 5'h1F; rw = 1'b1; m2r = 1'b1;
        mem_if.i_mem_ack = 1'b0; mem_if.i_mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ReadData", rdata_o, 32'd0);
        check("reset ALU", alu_o, 32'd0);
        check("reset RegDest", 32'(rd_o), 32'd0);
        check("reset MemToReg", 32'(o_m2r), 32'd0);
        check("reset RegWrite", 32'(o_rw), 32'd0);
        check("reset misaligned", 32'(misal), 32'd0);
        check("reset bus_error", 32'(berr), 32'd0);
        check("reset req", 32'(mem_if.o_mem_req), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_nop();

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], i);
            if (i == 11) stray_ack();
        end

        // Reset asserted while a load is pending: request drops on the next cycle.
        @(posedge clk); #1;
        alu = 32'h30; mem_read = 1'b1; taml = 2'b10; rdest = 5'd3; rw = 1'b1; m2r = 1'b1;
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        check("midreset req_before", 32'(mem_if.o_mem_req), 32'd1);
        check("midreset stall_before", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset req", 32'(mem_if.o_mem_req), 32'd0);
        check("midreset stall", 32'(stall), 32'd0);
        check("midreset RegWrite", 32'(o_rw), 32'd0);
        check("midreset ALU", alu_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(vecs[13], 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
